// File: rtl/sw_reg_bank.sv
// sw_reg_bank: Wishbone slave exposing NUM_REGS byte-maskable control registers
// plus one read-only status word at offset NUM_REGS.
module sw_reg_bank #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter logic [BUS_ADDR_WIDTH-1:0] DEV_BASE_ADDR = '0,
  parameter int NUM_REGS = 4,
  parameter logic [NUM_REGS*BUS_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic                               wbs_cyc_i,
  input  logic                               wbs_stb_i,
  input  logic                               wbs_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0]        wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]          wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]          wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]          wbs_dat_o,
  output logic                               wbs_ack_o,
  output logic                               wbs_err_o,
  output logic [NUM_REGS*BUS_DATA_WIDTH-1:0] fabric_data_o,
  output logic [NUM_REGS-1:0]                fabric_wr_o,
  input  logic [BUS_DATA_WIDTH-1:0]          fabric_status_i
);
  localparam int BYTE_ENABLES = BUS_DATA_WIDTH/8;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic [NUM_REGS-1:0][BUS_DATA_WIDTH-1:0] regs;
  logic [BUS_ADDR_WIDTH-1:0] offset;
  logic [32:0] off_x;
  logic [IW-1:0] idx;
  logic [BUS_DATA_WIDTH-1:0] wmask;
  logic in_win, req, is_status, active;
  assign offset = wbs_adr_i - DEV_BASE_ADDR;
  assign off_x = 33'(offset);
  assign in_win = wbs_adr_i >= DEV_BASE_ADDR && off_x <= 33'(NUM_REGS);
  assign active = wbs_cyc_i && wbs_stb_i;
  assign req = state == IDLE && active && in_win;
  assign is_status = off_x == 33'(NUM_REGS);
  assign idx = offset[IW-1:0];
  assign fabric_data_o = regs;
  for (genvar b = 0; b < BYTE_ENABLES; b++) begin : g_mask
    assign wmask[8*b +: 8] = {8{wbs_sel_i[b]}};
  end
  // RESP is left only once the master drops cyc or stb, so a held strobe cannot start a second access
  always_comb begin
    state_nx = req || (state == RESP && active) ? RESP : IDLE;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      wbs_ack_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= '0;
      fabric_wr_o <= '0;
      regs        <= RESET_VALUE;
    end else begin
      state       <= state_nx;
      fabric_wr_o <= '0;
      if (req) begin
        wbs_ack_o <= !(is_status && wbs_we_i);
        wbs_err_o <= is_status && wbs_we_i;
        if (!wbs_we_i) begin
          wbs_dat_o <= is_status ? fabric_status_i : regs[idx];
        end else if (!is_status) begin
          regs[idx]        <= (regs[idx] & ~wmask) | (wbs_dat_i & wmask);
          fabric_wr_o[idx] <= |wbs_sel_i;
        end
      end else if (!active) begin
        wbs_ack_o <= 1'b0;
        wbs_err_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sw_reg_bank.sv
// tb_sw_reg_bank: directed table, hand sequences and random traffic against
// an array-based model of the register bank.
module tb_sw_reg_bank;
  localparam logic [7:0] BASE = 8'h10;
  localparam logic [127:0] RV = {32'h0000_FF33, 32'hA5A5_0000, 32'h0, 32'h0};
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = '0;
  logic [7:0] adr = '0;
  logic [31:0] dat_i = '0, status = '0, dat_o;
  logic ack, err;
  logic [127:0] fdata;
  logic [3:0] fwr;
  int errors = 0, checks = 0;
  logic [31:0] m_reg [4];
  logic [31:0] m_dat;
  logic e_ack, e_err;
  logic [3:0] e_wr;
  typedef struct {
    logic we; logic [7:0] adr; logic [31:0] dat; logic [3:0] sel; logic [31:0] st;
    logic ack; logic err; logic [3:0] wr; logic [31:0] rd;
  } vec_t;
  vec_t tbl [12];

  sw_reg_bank #(.BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(8), .DEV_BASE_ADDR(BASE),
                .NUM_REGS(4), .RESET_VALUE(RV)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
    .wbs_ack_o(ack), .wbs_err_o(err), .fabric_data_o(fdata), .fabric_wr_o(fwr),
    .fabric_status_i(status));

  always #5 clk = ~clk;

  function automatic logic [127:0] m_pack();
    return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) m_reg[k] = RV[32*k +: 32];
    m_dat = '0;
  endtask

  // drive one request and advance the model; returns 1ns after the request edge
  task automatic apply(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] st);
    int off;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s; status = st;
    e_ack = 0; e_err = 0; e_wr = '0;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off <= 4) begin
      if (off == 4) begin
        if (w) e_err = 1;
        else begin e_ack = 1; m_dat = st; end
      end else begin
        e_ack = 1;
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) m_reg[off][8*b +: 8] = d[8*b +: 8];
          if (s != 0) e_wr[off] = 1'b1;
        end else m_dat = m_reg[off];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_ack"}, 128'(ack), 128'(e_ack));
    chk({tag, "_err"}, 128'(err), 128'(e_err));
    chk({tag, "_wr"}, 128'(fwr), 128'(e_wr));
    chk({tag, "_dat"}, 128'(dat_o), 128'(m_dat));
    chk({tag, "_fdata"}, fdata, m_pack());
    chk({tag, "_excl"}, 128'(ack & err), 128'(0));
  endtask

  task automatic release_bus(input string tag);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    chk({tag, "_rel_ack"}, 128'(ack), 128'(0));
    chk({tag, "_rel_err"}, 128'(err), 128'(0));
    chk({tag, "_rel_wr"}, 128'(fwr), 128'(0));
  endtask

  initial begin
    tbl[0]  = '{1, 8'h11, 32'h1234_5678, 4'b0101, 32'h0,         1, 0, 4'b0010, 32'h0};
    tbl[1]  = '{0, 8'h11, 32'h0,         4'b1111, 32'h0,         1, 0, 4'b0000, 32'h0034_0078};
    tbl[2]  = '{0, 8'h14, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1, 0, 4'b0000, 32'hDEAD_BEEF};
    tbl[3]  = '{1, 8'h14, 32'hFFFF_FFFF, 4'b1111, 32'h0,         0, 1, 4'b0000, 32'hDEAD_BEEF};
    tbl[4]  = '{0, 8'h0F, 32'h0,         4'b1111, 32'h0,         0, 0, 4'b0000, 32'hDEAD_BEEF};
    tbl[5]  = '{1, 8'h15, 32'hFFFF_FFFF, 4'b1111, 32'h0,         0, 0, 4'b0000, 32'hDEAD_BEEF};
    tbl[6]  = '{1, 8'h12, 32'hFFFF_FFFF, 4'b0000, 32'h0,         1, 0, 4'b0000, 32'hDEAD_BEEF};
    tbl[7]  = '{0, 8'h12, 32'h0,         4'b1111, 32'h0,         1, 0, 4'b0000, 32'hA5A5_0000};
    tbl[8]  = '{1, 8'h10, 32'hCAFE_BABE, 4'b1010, 32'h0,         1, 0, 4'b0001, 32'hA5A5_0000};
    tbl[9]  = '{0, 8'h10, 32'h0,         4'b1111, 32'h0,         1, 0, 4'b0000, 32'hCA00_BA00};
    tbl[10] = '{1, 8'h13, 32'h1122_3344, 4'b1111, 32'h0,         1, 0, 4'b1000, 32'hCA00_BA00};
    tbl[11] = '{0, 8'h13, 32'h0,         4'b1111, 32'h0,         1, 0, 4'b0000, 32'h1122_3344};
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_fdata", fdata, RV);
    chk("rst_slice2", 128'(fdata[95:64]), 128'(32'hA5A5_0000));
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_dat", 128'(dat_o), 128'(0));
    chk("rst_wr", 128'(fwr), 128'(0));
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].st);
      chk($sformatf("tbl%0d_ack", i), 128'(ack), 128'(tbl[i].ack));
      chk($sformatf("tbl%0d_err", i), 128'(err), 128'(tbl[i].err));
      chk($sformatf("tbl%0d_wr", i), 128'(fwr), 128'(tbl[i].wr));
      chk($sformatf("tbl%0d_dat", i), 128'(dat_o), 128'(tbl[i].rd));
      chk($sformatf("tbl%0d_fdata", i), fdata, m_pack());
      release_bus($sformatf("tbl%0d", i));
    end
    chk("tbl_reg1", 128'(fdata[63:32]), 128'(32'h0034_0078));
    // ack held while stb stays high, pulse lasts one cycle only
    apply(1, 8'h11, 32'hAABB_CCDD, 4'b1111, 32'h0);
    check_out("hold0");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("hold_ack", 128'(ack), 128'(1));
      chk("hold_wr", 128'(fwr), 128'(0));
    end
    release_bus("hold");
    // held strobe with changed address/data must not start a second write
    apply(1, 8'h12, 32'h1111_1111, 4'b1111, 32'h0);
    check_out("b2b0");
    adr = 8'h10; dat_i = 32'h2222_2222;
    repeat (2) begin
      @(posedge clk); #1;
      chk("b2b_ack", 128'(ack), 128'(1));
      chk("b2b_wr", 128'(fwr), 128'(0));
      chk("b2b_fdata", fdata, m_pack());
    end
    release_bus("b2b_gap");
    apply(1, 8'h10, 32'h2222_2222, 4'b1111, 32'h0);
    check_out("b2b1");
    release_bus("b2b1");
    // reset while ack is high aborts the cycle asynchronously
    apply(1, 8'h13, 32'h5555_AAAA, 4'b1111, 32'h0);
    check_out("arst0");
    #2 rst = 1; cyc = 0; stb = 0;
    #1;
    chk("arst_ack", 128'(ack), 128'(0));
    chk("arst_dat", 128'(dat_o), 128'(0));
    chk("arst_reg3", 128'(fdata[127:96]), 128'(32'h0000_FF33));
    @(posedge clk); #1 rst = 0;
    m_reset();
    apply(0, 8'h13, 32'h0, 4'b1111, 32'h0);
    check_out("arst_idle");
    release_bus("arst_idle");
    for (int i = 0; i < 200; i++) begin
      apply(1'($urandom_range(0, 1)), 8'($urandom_range(14, 22)), $urandom,
            4'($urandom_range(0, 15)), $urandom);
      check_out($sformatf("rnd%0d", i));
      release_bus($sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sw_reg_bank.md
SW_REG_BANK -- requirements
Module: sw_reg_bank

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 32, bus/register width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter BUS_ADDR_WIDTH, default 8, word-address width; legal values 4, 8, 16, 32.
REQ-003 SHALL have parameter DEV_BASE_ADDR, default 0, word address of register 0.
REQ-004 SHALL have parameter NUM_REGS, default 4, number of read/write control registers; legal range 1..16.
REQ-005 SHALL have parameter RESET_VALUE, default all-zero, NUM_REGS*BUS_DATA_WIDTH bits; register k resets to slice k.
REQ-006 SHALL have localparam BYTE_ENABLES = BUS_DATA_WIDTH/8.
REQ-007 Ports: one clock; reset is asynchronous and active-high.
REQ-008 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-009 wb_rst_i  in  1  asynchronous active-high reset.
REQ-010 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-011 wbs_sel_i  in  BYTE_ENABLES  byte lane enables, bit n = bits [8n+7:8n].
REQ-012 wbs_adr_i  in  BUS_ADDR_WIDTH  word address.
REQ-013 wbs_dat_i  in  BUS_DATA_WIDTH  write data.
REQ-014 wbs_dat_o  out  BUS_DATA_WIDTH  registered read data.
REQ-015 wbs_ack_o, wbs_err_o  out  1 each  registered termination.
REQ-016 fabric_data_o  out  NUM_REGS*BUS_DATA_WIDTH  register k on slice [k*W+W-1:k*W].
REQ-017 fabric_wr_o  out  NUM_REGS  one-cycle pulse, bit k high the cycle after register k is updated.
REQ-018 fabric_status_i  in  BUS_DATA_WIDTH  read-only status word.

Function
REQ-019 offset = wbs_adr_i - DEV_BASE_ADDR; in-window iff DEV_BASE_ADDR <= wbs_adr_i <= DEV_BASE_ADDR+NUM_REGS.
REQ-020 Offsets 0..NUM_REGS-1 SHALL map to control registers; offset NUM_REGS SHALL map to status (read-only).
REQ-021 FSM states IDLE, RESP; reset state IDLE.
REQ-022 IDLE: request = cyc & stb & in-window; on request, perform access this edge, assert ack or err, go RESP; out-of-window requests SHALL be ignored (no ack, no err, no change).
REQ-023 RESP: hold ack/err high while cyc & stb high; when either drops, clear ack/err next edge and return to IDLE; no new request accepted in RESP.
REQ-024 Latency: ack/err rises exactly 1 cycle after the request edge.
REQ-025 Control write: update only lanes with wbs_sel_i set; ack; fabric_wr_o[offset] pulses 1 cycle if any sel bit set, none if sel = 0.
REQ-026 Control read: wbs_dat_o <= register[offset]; ack; wbs_dat_o holds until next read.
REQ-027 Status read: wbs_dat_o <= fabric_status_i sampled at the request edge; ack.
REQ-028 Status write: no state change, no pulse, err asserted instead of ack.
REQ-029 ack and err SHALL never be high together.
REQ-030 fabric_data_o SHALL be driven directly from register storage; new value visible the cycle ack rises.

Reset
REQ-031 On wb_rst_i high, immediately: state IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, fabric_wr_o=0, register k = RESET_VALUE slice k.
REQ-032 Reset during RESP SHALL abort the cycle; after release the master must re-issue the request.

Verification (W=32, AW=8, NUM_REGS=4, DEV_BASE_ADDR=8'h10)
REQ-033 Reset release with RESET_VALUE slice 2 = 32'hA5A5_0000 -> fabric_data_o slice 2 = 32'hA5A5_0000, ack/err/dat_o = 0.
REQ-034 Write adr 8'h11, dat 32'h1234_5678, sel 4'b0101 over reg 0 -> reg1 = 32'h0034_0078, fabric_wr_o = 4'b0010 one cycle, ack 1 cycle after request, held until stb drops.
REQ-035 Read adr 8'h14 with fabric_status_i = 32'hDEAD_BEEF -> dat_o = 32'hDEAD_BEEF, ack; write adr 8'h14 -> err=1, ack=0, no fabric_wr_o.
REQ-036 Access adr 8'h0F and 8'h15 -> no ack, no err, registers unchanged; write sel=4'b0000 to 8'h12 -> ack, reg2 unchanged, no pulse.
REQ-037 Assert wb_rst_i while ack high after write to 8'h13 -> ack drops asynchronously, reg3 returns to RESET_VALUE slice 3, state IDLE.
REQ-038 Back-to-back: stb held high across two writes -> second write not performed until stb low for one edge and re-asserted.
